// File: rtl/reset_mode_controller_pkg.sv
// reset_mode_controller_pkg: region mode encoding, FSM states and LED colour table
// shared by the reset/mode controller files.
package reset_mode_controller_pkg;

    typedef enum logic [1:0] {
        MODE_NTSC_U = 2'd0,
        MODE_NTSC_J = 2'd1,
        MODE_PAL    = 2'd2,
        MODE_PAL60  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_CYCLE,
        ST_PULSE,
        ST_WAIT_REL
    } state_e;

    // {led_r, led_g} per mode, mode 3 in the top pair
    localparam logic [7:0] LED_TABLE = {2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [1:0] led_rg(input mode_e mode);
        return LED_TABLE[{mode, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/reset_mode_controller_if.sv
// reset_mode_controller_if: board-side signals of the reset/mode controller;
// master is the controller, slave is the board.
interface reset_mode_controller_if;

    logic       btn_raw;
    logic       console_reset_n;
    logic [1:0] mode;
    logic       pal_50hz;
    logic       led_r;
    logic       led_g;
    logic       mode_changed;

    modport master (
        input  btn_raw,
        output console_reset_n,
        output mode,
        output pal_50hz,
        output led_r,
        output led_g,
        output mode_changed
    );

    modport slave (
        output btn_raw,
        input  console_reset_n,
        input  mode,
        input  pal_50hz,
        input  led_r,
        input  led_g,
        input  mode_changed
    );

endinterface

// File: rtl/reset_mode_controller_sample_tick_gen.sv
// sample_tick_gen: registered one-clk tick every TICKS clk cycles.
module sample_tick_gen #(
    parameter int TICKS = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int TW = TICKS > 1 ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          tick_q;

    assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
    assign tick_o = tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == LAST);
        end
    end

endmodule

// File: rtl/reset_mode_controller.sv
// reset_mode_controller: debounced reset button; a short press pulses the console
// reset, a long hold cycles the region mode, and power-up issues one reset pulse.
module reset_mode_controller
    import reset_mode_controller_pkg::*;
#(
    parameter int   TICKS          = 500_000,
    parameter int   LONG_SAMPLES   = 100,
    parameter int   RESET_SAMPLES  = 20,
    parameter logic BTN_ACTIVE_LOW = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    reset_mode_controller_if.master board
);

    localparam int MAX_S = LONG_SAMPLES > RESET_SAMPLES ? LONG_SAMPLES : RESET_SAMPLES;
    localparam int CW    = $clog2(MAX_S) + 1;
    localparam logic [CW-1:0] LONG_C  = CW'(LONG_SAMPLES);
    localparam logic [CW-1:0] RESET_C = CW'(RESET_SAMPLES);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_S);

    logic          tick;
    logic [1:0]    sync_q;
    logic          sample;
    logic          smp_q, smp_d;
    logic          btn_q, btn_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    mode_e         mode_q, mode_d;
    logic          por_q, por_d;
    logic [1:0]    blink_q, blink_d;
    logic          console_q, console_d;
    logic          changed_q, changed_d;
    logic [1:0]    led_q, led_d;
    logic          pal_q, pal_d;

    sample_tick_gen #(.TICKS(TICKS)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign sample  = sync_q[1] ^ BTN_ACTIVE_LOW;
    assign smp_d   = tick ? sample : smp_q;
    // btn follows only two consecutive equal samples, so a one-sample glitch never lands
    assign btn_d   = (tick && sample == smp_q) ? sample : btn_q;
    assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {2{BTN_ACTIVE_LOW}};
            smp_q     <= 1'b0;
            btn_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_NTSC_U;
            por_q     <= 1'b1;
            blink_q   <= '0;
            console_q <= 1'b0;
            changed_q <= 1'b0;
            led_q     <= 2'b00;
            pal_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], board.btn_raw};
            smp_q     <= smp_d;
            btn_q     <= btn_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            por_q     <= por_d;
            blink_q   <= blink_d;
            console_q <= console_d;
            changed_q <= changed_d;
            led_q     <= led_d;
            pal_q     <= pal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        por_d     = por_q;
        changed_d = 1'b0;
        blink_d   = tick ? blink_q + 2'd1 : blink_q;
        case (state_q)
            ST_IDLE: begin
                // the power-on pulse starts already counted, since the console is held low from reset
                if (por_q) begin
                    if (tick) begin
                        state_d = ST_PULSE;
                        cnt_d   = CW'(1);
                        por_d   = 1'b0;
                    end
                end else if (btn_q) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_PRESS, ST_CYCLE: begin
                if (!btn_q) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc == LONG_C) begin
                        state_d   = ST_CYCLE;
                        cnt_d     = '0;
                        mode_d    = mode_e'(mode_q + 2'd1);
                        changed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_PULSE: begin
                if (tick) begin
                    if (cnt_q == RESET_C) begin
                        state_d = btn_q ? ST_WAIT_REL : ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_WAIT_REL: state_d = btn_q ? ST_WAIT_REL : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // console is low from the first tick inside PULSE until RESET_SAMPLES ticks later
        console_d = !(por_d || (state_d == ST_PULSE && cnt_d != '0));
        led_d     = led_rg(mode_d) & ((state_d == ST_CYCLE && blink_d[1]) ? 2'b00 : 2'b11);
        pal_d     = (mode_d == MODE_PAL);
    end

    assign board.console_reset_n = console_q;
    assign board.mode            = mode_q;
    assign board.pal_50hz        = pal_q;
    assign board.led_r           = led_q[1];
    assign board.led_g           = led_q[0];
    assign board.mode_changed    = changed_q;

endmodule

// File: tb/tb_reset_mode_controller.sv
// tb_reset_mode_controller: scoreboard bench; expected reset pulse widths and mode
// advances are queued with the stimulus and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_reset_mode_controller;

    localparam int TICKS         = 4;
    localparam int LONG_SAMPLES  = 10;
    localparam int RESET_SAMPLES = 3;
    localparam int PULSE_CLK     = TICKS * RESET_SAMPLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reset_mode_controller_if board ();

    reset_mode_controller #(
        .TICKS          (TICKS),
        .LONG_SAMPLES   (LONG_SAMPLES),
        .RESET_SAMPLES  (RESET_SAMPLES),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .board (board)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   exp_w[$];
    int   exp_m[$];
    logic mon_en    = 1'b0;
    logic blink_mon = 1'b0;
    int   low_cnt   = 0;
    int   toggles   = 0;
    logic prev_g    = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    // scoreboard consumer: each finished low pulse and each mode_changed pulse pops one entry
    always @(negedge clk) begin
        if (!mon_en) low_cnt = 0;
        else if (!board.console_reset_n) low_cnt++;
        else if (low_cnt != 0) begin
            if (exp_w.size() == 0) check("unexpected_pulse", low_cnt, 0);
            else check("pulse_width", low_cnt, exp_w.pop_front());
            low_cnt = 0;
        end
        if (mon_en && board.mode_changed) begin
            if (exp_m.size() == 0) check("unexpected_advance", int'(board.mode_changed), 0);
            else begin
                int e;
                e = exp_m.pop_front();
                check("mode_adv", int'(board.mode), e);
                check("pal_on_adv", int'(board.pal_50hz), int'(e == 2));
            end
        end
        if (blink_mon && board.mode == 2'd0 && board.led_g != prev_g) toggles++;
        prev_g = board.led_g;
    end

    // pressed samples of raw button (active low), each sample TICKS clk long
    task automatic drive(input logic pressed, input int samples);
        board.btn_raw = ~pressed;
        repeat (samples * TICKS) @(posedge clk);
        #1;
    endtask

    task automatic por_release(input string tag);
        int   w;
        logic done;
        w    = 0;
        done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (board.console_reset_n) done = 1'b1;
            else w++;
        end
        check({tag, "_por_end"}, int'(done), 1);
        check({tag, "_por_len"}, int'(w >= PULSE_CLK && w <= PULSE_CLK + 2 * TICKS), 1);
        check({tag, "_por_mode"}, int'(board.mode), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_console"}, int'(board.console_reset_n), 0);
        check({tag, "_mode"}, int'(board.mode), 0);
        check({tag, "_changed"}, int'(board.mode_changed), 0);
        check({tag, "_led_r"}, int'(board.led_r), 0);
        check({tag, "_led_g"}, int'(board.led_g), 0);
        check({tag, "_pal"}, int'(board.pal_50hz), 0);
    endtask

    task automatic check_leds(input string tag, input int r, input int g, input int pal);
        check({tag, "_led_r"}, int'(board.led_r), r);
        check({tag, "_led_g"}, int'(board.led_g), g);
        check({tag, "_pal"}, int'(board.pal_50hz), pal);
    endtask

    initial begin
        logic seen;
        board.btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        por_release("boot");
        mon_en = 1'b1;
        check_leds("boot", 0, 1, 0);

        // bouncy short press: glitches on both edges, one pulse, no advance
        exp_w.push_back(PULSE_CLK);
        drive(1, 1); drive(0, 1); drive(1, 5); drive(0, 1); drive(1, 1); drive(0, 12);
        check("glitch_mode", int'(board.mode), 0);
        check("glitch_left", exp_w.size(), 0);

        // 25-sample hold: two advances then one pulse
        exp_m.push_back(1); exp_m.push_back(2); exp_w.push_back(PULSE_CLK);
        drive(1, 25); drive(0, 12);
        check("hold25_mode", int'(board.mode), 2);
        check_leds("hold25", 1, 0, 1);
        check("hold25_left", exp_w.size() + exp_m.size(), 0);

        // one sample short of a long press: no advance
        exp_w.push_back(PULSE_CLK);
        drive(1, 9); drive(0, 12);
        check("hold9_mode", int'(board.mode), 2);
        check("hold9_left", exp_w.size(), 0);

        // exactly a long press: one advance
        exp_m.push_back(3); exp_w.push_back(PULSE_CLK);
        drive(1, 10); drive(0, 12);
        check("hold10_mode", int'(board.mode), 3);
        check_leds("hold10", 0, 0, 0);

        // wrap 3 -> 0 and led_g blinking while still cycling
        exp_m.push_back(0); exp_w.push_back(PULSE_CLK);
        toggles   = 0;
        blink_mon = 1'b1;
        drive(1, 18); drive(0, 2);
        blink_mon = 1'b0;
        drive(0, 10);
        check("wrap_blink", int'(toggles >= 2), 1);
        check("wrap_mode", int'(board.mode), 0);
        check_leds("wrap", 0, 1, 0);
        check("wrap_left", exp_w.size() + exp_m.size(), 0);

        // press during PULSE: width unchanged, held past the pulse, no second reset
        exp_w.push_back(PULSE_CLK);
        drive(1, 5);
        board.btn_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!board.console_reset_n) seen = 1'b1;
        end
        check("inpulse_start", int'(seen), 1);
        @(posedge clk);
        #1;
        drive(1, 8); drive(0, 14);
        check("inpulse_left", exp_w.size(), 0);
        check("inpulse_mode", int'(board.mode), 0);

        // reset asserted mid-cycle at mode 2
        exp_m.push_back(1); exp_m.push_back(2);
        board.btn_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 * TICKS && !seen; i++) begin
            @(negedge clk);
            if (board.mode == 2'd2) seen = 1'b1;
        end
        check("cyc_reach_mode2", int'(seen), 1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_state("midrst");
        board.btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        por_release("midrst");
        mon_en = 1'b1;
        drive(0, 12);
        check("midrst_mode", int'(board.mode), 0);
        check("end_left", exp_w.size() + exp_m.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/reset_mode_controller.md
RESET_MODE_CONTROLLER -- requirements
Module: reset_mode_controller

Interface
REQ-001 Parameter TICKS, default 500_000, clk cycles per sample tick (10 ms @ 50 MHz).
REQ-002 Parameter LONG_SAMPLES, default 100, samples held before a press counts as long (1 s).
REQ-003 Parameter RESET_SAMPLES, default 20, console reset pulse width in samples (200 ms).
REQ-004 Parameter BTN_ACTIVE_LOW, default 1'b1, raw button polarity.
REQ-005 clk  in  1  system clock; one clock domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 btn_raw  in  1  raw reset button, unsynchronised, bouncing.
REQ-008 console_reset_n  out  1  reset to console, active low.
REQ-009 mode  out  2  region mode: 0 NTSC-U, 1 NTSC-J, 2 PAL, 3 PAL-60.
REQ-010 pal_50hz  out  1  high when mode==2.
REQ-011 led_r, led_g  out  1 each  mode colour; blinks while cycling.
REQ-012 mode_changed  out  1  one-clk pulse per mode advance.

Function
REQ-013 btn_raw SHALL pass a 2-flop synchroniser, then be sampled once per tick; tick asserts one clk every TICKS cycles.
REQ-014 Debounced level btn SHALL change only after 2 consecutive equal samples differing from current btn.
REQ-015 FSM states: IDLE, PRESS, CYCLE, PULSE, WAIT_REL.
REQ-016 IDLE: btn asserted -> PRESS, hold counter cleared to 0.
REQ-017 PRESS: counter +1 per tick; btn released with counter < LONG_SAMPLES -> PULSE; counter reaching LONG_SAMPLES -> CYCLE with mode advanced.
REQ-018 CYCLE: mode advances every further LONG_SAMPLES ticks held; release -> PULSE.
REQ-019 Mode advance SHALL wrap 3 -> 0, modulo-4 in 2 bits; mode_changed pulses the same clk mode updates.
REQ-020 PULSE: console_reset_n low exactly RESET_SAMPLES ticks, counted from the first tick after entry, then high.
REQ-021 After PULSE: btn still asserted -> WAIT_REL, else IDLE; WAIT_REL -> IDLE on release, no new reset.
REQ-022 Presses during PULSE SHALL be ignored; a press never truncates or extends the pulse.
REQ-023 LED colour: mode0 G, mode1 R+G, mode2 R, mode3 off; in CYCLE both toggle-masked with 4-sample period.
REQ-024 Counters SHALL saturate at their limit, never wrap; width = clog2 of largest parameter + 1.
REQ-025 Console reset SHALL assert within 1 tick of a debounced release.

Reset
REQ-026 rst_n low: FSM IDLE, counters 0, mode 0, console_reset_n 0, mode_changed 0, LEDs off.
REQ-027 First tick after rst_n rises: FSM enters PULSE (power-on reset of console, RESET_SAMPLES ticks).
REQ-028 rst_n mid-press or mid-cycle SHALL discard the press; mode returns to 0.

Structure
REQ-029 Shared package holds mode encoding constants, FSM state enum, LED colour table.
REQ-030 One sub-module, sample_tick_gen: tick counter with TICKS parameter and async active-low reset.
REQ-031 All outputs SHALL be registered.

Verification (TICKS=4, LONG_SAMPLES=10, RESET_SAMPLES=3)
REQ-032 Release rst_n, btn idle -> console_reset_n low 12 clk (3 ticks) then high, mode=0.
REQ-033 Press 5 samples with 1-sample glitches at edges -> single reset pulse of 3 ticks, mode unchanged.
REQ-034 Hold 25 samples -> mode 0->1->2, two mode_changed pulses, pal_50hz=1, one reset pulse after release.
REQ-035 From mode 3, hold 10 samples -> mode=0 (wrap), led_g blinking during CYCLE.
REQ-036 Press again during PULSE -> pulse still exactly 3 ticks, WAIT_REL, no second reset.
REQ-037 Assert rst_n in CYCLE at mode=2 -> mode=0, console_reset_n=0 immediately.
